// File: rtl/ps2_device_tx_pkg.sv
// Shared PS/2 definitions: default timing, transmit FSM states and the
// helper that builds an 11-bit device-to-host frame from a scancode byte.
package ps2_device_tx_pkg;

  localparam int PS2_HALFBIT     = 1000;
  localparam int PS2_IDLEWAIT    = 1400;
  localparam int PS2_TX_DEPTH    = 8;
  localparam int PS2_FRAME_BITS  = 11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAITBUS = 3'd1,
    CLKHI   = 3'd2,
    CLKLO   = 3'd3,
    DONE    = 3'd4
  } ps2_tx_state_e;

  // Bit 0 goes on the wire first: start, data LSB first, odd parity, stop.
  function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] b);
    return {1'b1, ~(^b), b, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_device_tx_if.sv
// Host-side bus of the PS/2 device transmitter: byte push strobe plus
// queue and line status flags.
interface ps2_device_tx_if;

  logic [7:0] data;
  logic       dataload;
  logic       fifo_full;
  logic       fifo_empty;
  logic       ps2busy;
  logic       aborted;

  modport master (
    output data,
    output dataload,
    input  fifo_full,
    input  fifo_empty,
    input  ps2busy,
    input  aborted
  );

  modport slave (
    input  data,
    input  dataload,
    output fifo_full,
    output fifo_empty,
    output ps2busy,
    output aborted
  );

endinterface

// File: rtl/ps2_tx_fifo.sv
// Small scancode queue for the PS/2 transmitter; an occupancy counter one bit
// wider than the pointers keeps full and empty unambiguous.
module ps2_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [7:0]       mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  // A push while full is dropped, so nothing moves in that case.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // DEPTH is a power of two, so plain pointer overflow gives the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_device_tx.sv
// PS/2 device-side transmitter: queues scancodes and clocks each one out as an
// 11-bit frame on open-drain clock/data lines, retrying whole frames on inhibit.
module ps2_device_tx
  import ps2_device_tx_pkg::*;
#(
  parameter int HALFBIT  = PS2_HALFBIT,
  parameter int IDLEWAIT = PS2_IDLEWAIT,
  parameter int DEPTH    = PS2_TX_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  ps2_device_tx_if.slave    bus,
  inout  wire               ps2clk_ext,
  inout  wire               ps2data_ext
);

  localparam int MAXWAIT = (HALFBIT > IDLEWAIT) ? HALFBIT : IDLEWAIT;
  localparam int CW      = $clog2(MAXWAIT + 1);

  localparam logic [CW-1:0] HALF_LAST = CW'(HALFBIT - 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLEWAIT - 1);
  localparam logic [3:0]    BIT_LAST  = 4'(PS2_FRAME_BITS - 1);

  ps2_tx_state_e              state;
  ps2_tx_state_e              state_next;
  logic [CW-1:0]              cnt;
  logic [CW-1:0]              cnt_next;
  logic [3:0]                 bit_cnt;
  logic [3:0]                 bit_next;
  logic [PS2_FRAME_BITS-1:0]  shifter;
  logic [PS2_FRAME_BITS-1:0]  shifter_next;
  logic                       abort_now;
  logic                       aborted_q;
  logic                       pop;

  logic                       clk_meta;
  logic                       clk_s;
  logic                       dat_meta;
  logic                       dat_s;

  logic [7:0]                 head;
  logic                       full;
  logic                       empty;
  logic                       drive_clk;
  logic                       drive_dat;

  ps2_tx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.dataload),
    .din   (bus.data),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // Lines idle high through the external pull-ups, hence the reset value 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta <= 1'b1;
      clk_s    <= 1'b1;
      dat_meta <= 1'b1;
      dat_s    <= 1'b1;
    end else begin
      clk_meta <= ps2clk_ext;
      clk_s    <= clk_meta;
      dat_meta <= ps2data_ext;
      dat_s    <= dat_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shifter   <= '0;
      aborted_q <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      bit_cnt   <= bit_next;
      shifter   <= shifter_next;
      aborted_q <= abort_now;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    bit_next     = bit_cnt;
    shifter_next = shifter;
    abort_now    = 1'b0;
    pop          = 1'b0;

    case (state)
      IDLE: begin
        if (!empty) begin
          state_next = WAITBUS;
          cnt_next   = '0;
        end
      end

      // A host request-to-send pulls data low, which simply keeps us here.
      WAITBUS: begin
        if (clk_s && dat_s) begin
          if (cnt == IDLE_LAST) begin
            shifter_next = ps2_frame(head);
            bit_next     = '0;
            cnt_next     = '0;
            state_next   = CLKHI;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end else begin
          cnt_next = '0;
        end
      end

      // Clock is released here, so a low synchronized clock means the host.
      CLKHI: begin
        if (cnt == HALF_LAST) begin
          cnt_next = '0;
          if (!clk_s) begin
            abort_now  = 1'b1;
            state_next = WAITBUS;
          end else begin
            state_next = CLKLO;
          end
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end

      CLKLO: begin
        if (cnt == HALF_LAST) begin
          cnt_next     = '0;
          shifter_next = {1'b1, shifter[PS2_FRAME_BITS-1:1]};
          if (bit_cnt == BIT_LAST) begin
            state_next = DONE;
          end else begin
            bit_next   = bit_cnt + 4'd1;
            state_next = CLKHI;
          end
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end

      DONE: begin
        pop        = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Drivers decode the registered state, so reset releases both lines at once.
  assign drive_clk = (state == CLKLO);
  assign drive_dat = ((state == CLKHI) || (state == CLKLO)) && !shifter[0];

  assign ps2clk_ext  = drive_clk ? 1'b0 : 1'bz;
  assign ps2data_ext = drive_dat ? 1'b0 : 1'bz;

  assign bus.fifo_full  = full;
  assign bus.fifo_empty = empty;
  assign bus.ps2busy    = (state == CLKHI) || (state == CLKLO) || (state == DONE);
  assign bus.aborted    = aborted_q;

endmodule

// File: tb/tb_ps2_device_tx.sv
// Scoreboard bench for ps2_device_tx: pushes queue expected frames, a host-side
// monitor decodes falling-edge samples off the pulled-up lines and compares.
module tb_ps2_device_tx;

  localparam int HALFBIT  = 4;
  localparam int IDLEWAIT = 6;
  localparam int DEPTH    = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic host_inhibit = 1'b0;

  wire ps2clk_line;
  wire ps2data_line;

  pullup pu_clk (ps2clk_line);
  pullup pu_dat (ps2data_line);

  assign ps2clk_line = host_inhibit ? 1'b0 : 1'bz;

  ps2_device_tx_if bus ();

  ps2_device_tx #(
    .HALFBIT  (HALFBIT),
    .IDLEWAIT (IDLEWAIT),
    .DEPTH    (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .ps2clk_ext  (ps2clk_line),
    .ps2data_ext (ps2data_line)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];
  int frames_done = 0;
  int abort_count = 0;
  int bit_idx = 0;
  int idle_run = 0;
  int last_idle = 0;
  logic prev_clk = 1'b1;
  logic [10:0] cur_frame = '0;
  logic [10:0] last_frame = '0;

  // Reference frame from the protocol rules: start 0, LSB-first data,
  // parity making the total count of ones odd, stop 1.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    ones = 0;
    f = '0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = (((b >> i) & 8'd1) != 0);
      ones += int'((b >> i) & 8'd1);
    end
    f[9]  = ((ones % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(posedge clk);
    #1;
    bus.data     = b;
    bus.dataload = 1'b1;
    if (exp_q.size() < DEPTH) begin
      exp_q.push_back(b);
    end
    @(posedge clk);
    #1;
    bus.dataload = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 32'(frames_done >= target), 32'd1);
  endtask

  // Monitor: host view of the wire, sampled mid-cycle away from DUT edges.
  initial begin
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bit_idx  = 0;
        idle_run = 0;
      end else begin
        if (ps2clk_line === 1'b1 && ps2data_line === 1'b1) begin
          idle_run++;
        end else begin
          if (idle_run != 0) last_idle = idle_run;
          idle_run = 0;
        end
        if (bus.aborted === 1'b1) begin
          abort_count++;
          bit_idx = 0;
        end
        if (prev_clk === 1'b1 && ps2clk_line === 1'b0 && !host_inhibit) begin
          if (bit_idx == 0) begin
            checkOutput("idle_gap_before_frame", 32'(last_idle >= IDLEWAIT), 32'd1);
          end
          cur_frame[bit_idx] = ps2data_line;
          bit_idx++;
          if (bit_idx == 11) begin
            bit_idx    = 0;
            last_frame = cur_frame;
            frames_done++;
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("[TB] FAIL unexpected_frame: got 0x%0h, expected no frame", cur_frame);
            end else begin
              exp_b = exp_q.pop_front();
              checkOutput("frame_vs_model", 32'(cur_frame), 32'(model_frame(exp_b)));
            end
          end
        end
      end
      prev_clk = ps2clk_line;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int f0;
    int a0;
    int n;

    bus.data     = '0;
    bus.dataload = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_fifo_empty", 32'(bus.fifo_empty), 32'd1);
    checkOutput("reset_fifo_full",  32'(bus.fifo_full),  32'd0);
    checkOutput("reset_ps2busy",    32'(bus.ps2busy),    32'd0);
    checkOutput("reset_aborted",    32'(bus.aborted),    32'd0);
    checkOutput("reset_clk_line",   32'(ps2clk_line),    32'd1);
    checkOutput("reset_data_line",  32'(ps2data_line),   32'd1);
    rst_n = 1'b1;

    // Single 0x1C frame, checked against the literal bit sequence too.
    applyStimulus(8'h1C);
    wait_frames(frames_done + 1, 2000, "frame_1C_timeout");
    checkOutput("frame_1C_bits", 32'(last_frame), 32'(11'b10000111000));
    repeat (HALFBIT + 4) @(negedge clk);
    checkOutput("empty_after_1C", 32'(bus.fifo_empty), 32'd1);
    checkOutput("idle_after_1C", 32'(bus.ps2busy), 32'd0);

    applyStimulus(8'h00);
    wait_frames(frames_done + 1, 2000, "frame_00_timeout");
    checkOutput("parity_00", 32'(last_frame[9]), 32'd1);

    // Back-to-back bytes: order via scoreboard, gap via the monitor.
    f0 = frames_done;
    applyStimulus(8'hF0);
    applyStimulus(8'h1C);
    wait_frames(f0 + 2, 4000, "back_to_back_timeout");

    // Third push lands while the first frame is being popped.
    applyStimulus(8'hA0);
    applyStimulus(8'hB1);
    f0 = frames_done;
    n = 0;
    while (frames_done == f0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (HALFBIT - 1) @(posedge clk);
    applyStimulus(8'hC2);
    wait_frames(f0 + 3, 4000, "push_pop_timeout");
    repeat (HALFBIT + 4) @(negedge clk);
    checkOutput("empty_after_push_pop", 32'(bus.fifo_empty), 32'd1);

    // Host inhibit during bit 5 of 0x5A, then a full resend.
    a0 = abort_count;
    f0 = frames_done;
    applyStimulus(8'h5A);
    n = 0;
    while (bit_idx != 5 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    host_inhibit = 1'b1;
    n = 0;
    while (abort_count == a0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checkOutput("abort_data_released", 32'(ps2data_line), 32'd1);
    checkOutput("abort_not_busy", 32'(bus.ps2busy), 32'd0);
    checkOutput("abort_head_kept", 32'(bus.fifo_empty), 32'd0);
    repeat (20) @(negedge clk);
    checkOutput("abort_pulses", 32'(abort_count - a0), 32'd1);
    host_inhibit = 1'b0;
    @(negedge clk);
    checkOutput("abort_clk_released", 32'(ps2clk_line), 32'd1);
    wait_frames(f0 + 1, 2000, "resend_timeout");
    checkOutput("resend_5A_bits", 32'(last_frame), 32'(11'b11010110100));
    checkOutput("abort_pulses_final", 32'(abort_count - a0), 32'd1);
    checkOutput("resend_frame_count", 32'(frames_done - f0), 32'd1);

    // DEPTH+1 random pushes with the bus inhibited.
    host_inhibit = 1'b1;
    repeat (4) @(negedge clk);
    f0 = frames_done;
    for (int i = 0; i <= DEPTH; i++) begin
      applyStimulus(8'($urandom));
    end
    @(negedge clk);
    checkOutput("overflow_full", 32'(bus.fifo_full), 32'd1);
    checkOutput("overflow_not_empty", 32'(bus.fifo_empty), 32'd0);
    repeat (40) @(negedge clk);
    checkOutput("no_frames_while_inhibited", 32'(frames_done - f0), 32'd0);
    host_inhibit = 1'b0;
    wait_frames(f0 + DEPTH, 4000, "overflow_drain_timeout");
    repeat (300) @(negedge clk);
    checkOutput("overflow_frame_count", 32'(frames_done - f0), 32'(DEPTH));
    checkOutput("overflow_drained_empty", 32'(bus.fifo_empty), 32'd1);

    // Randomized traffic with random gaps.
    f0 = frames_done;
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 60)) @(negedge clk);
      applyStimulus(8'($urandom));
    end
    wait_frames(f0 + 10, 6000, "random_timeout");
    repeat (HALFBIT + 4) @(negedge clk);
    checkOutput("random_empty", 32'(bus.fifo_empty), 32'd1);

    // Reset in the middle of a frame while the DUT holds the clock low.
    applyStimulus(8'hA5);
    applyStimulus(8'h3C);
    n = 0;
    while (!(bus.ps2busy === 1'b1 && ps2clk_line === 1'b0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("midframe_reached", 32'(ps2clk_line), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_clk_released", 32'(ps2clk_line), 32'd1);
    checkOutput("rst_data_released", 32'(ps2data_line), 32'd1);
    checkOutput("rst_not_busy", 32'(bus.ps2busy), 32'd0);
    checkOutput("rst_fifo_empty", 32'(bus.fifo_empty), 32'd1);
    exp_q.delete();
    f0 = frames_done;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    checkOutput("rst_discarded_bytes", 32'(frames_done - f0), 32'd0);
    applyStimulus(8'h77);
    wait_frames(f0 + 1, 2000, "post_reset_timeout");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_device_tx.md
PS2_DEVICE_TX -- requirements
Module: ps2_device_tx

Interface
REQ-001 Parameter HALFBIT, default 1000: clk cycles per half PS/2 clock period (about 14 kHz at 28 MHz clk).
REQ-002 Parameter IDLEWAIT, default 1400: clk cycles both lines must read high before a frame may start.
REQ-003 Parameter DEPTH, default 8: transmit FIFO entries (power of 2).
REQ-004 clk  input  1  single system clock; all logic on posedge clk.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 data  input  8  scancode byte to enqueue.
REQ-007 dataload  input  1  one-cycle push strobe for data.
REQ-008 ps2clk_ext  inout  1  open-drain PS/2 clock: driven 0 or Z, never driven 1.
REQ-009 ps2data_ext  inout  1  open-drain PS/2 data: driven 0 or Z, never driven 1.
REQ-010 fifo_full  output  1  FIFO holds DEPTH entries.
REQ-011 fifo_empty  output  1  FIFO holds 0 entries.
REQ-012 ps2busy  output  1  high while a frame is on the wire (states other than IDLE and WAITBUS).
REQ-013 aborted  output  1  one-cycle pulse when the host inhibits a frame mid-transmission.

Function
REQ-014 Both PS/2 lines SHALL pass through 2-flop synchronizers; all decisions use the synchronized values.
REQ-015 Push when dataload=1 and not full; a push while full SHALL be dropped with FIFO state unchanged.
REQ-016 Pointers SHALL wrap modulo DEPTH. An occupancy counter of log2(DEPTH)+1 bits SHALL drive the full and empty flags.
REQ-017 FSM states: IDLE, WAITBUS, CLKHI, CLKLO, DONE.
REQ-018 IDLE -> WAITBUS when the FIFO is not empty. The idle counter is cleared on entry.
REQ-019 WAITBUS: the counter increments while both synchronized lines are 1 and clears otherwise. At IDLEWAIT the FSM loads the head byte into an 11-bit shifter and goes to CLKHI.
REQ-020 Shifter contents, transmitted first to last: 0 (start), data[0..7] LSB first, odd parity (XOR of data inverted), 1 (stop).
REQ-021 CLKHI: clock released. The current bit is on data (0 = drive low, 1 = release) for HALFBIT cycles, then go to CLKLO.
REQ-022 In the last cycle of CLKHI, if synchronized ps2clk=0 (host inhibit), the FSM SHALL release both lines, pulse aborted, leave the FIFO head unpopped, and go to WAITBUS.
REQ-023 CLKLO: clock driven low for HALFBIT cycles, then shift. After the 11th bit go to DONE, otherwise go to CLKHI.
REQ-024 DONE: release both lines, pop the FIFO head, go to IDLE. The byte is retried in full after any abort.
REQ-025 A simultaneous push and pop SHALL leave occupancy unchanged and keep both data items correct.
REQ-026 An inhibit seen during CLKLO is ignored because the block itself is driving the clock low. It is detected at the next CLKHI check.
REQ-027 A host request-to-send (data low while clock high) SHALL only hold the FSM in WAITBUS. Receiving the host frame is out of scope.

Reset
REQ-028 When rst_n=0: FSM=IDLE, both lines released (Z), FIFO empty (fifo_empty=1, fifo_full=0), ps2busy=0, aborted=0, counters and shifter cleared.
REQ-029 Reset asserted mid-frame SHALL release both lines immediately, without waiting for a clock edge, and SHALL discard all queued bytes.

Structure
REQ-030 HALFBIT, IDLEWAIT and the FSM state encodings SHALL live in the shared PS/2 package or include used by the other PS/2 blocks.
REQ-031 The FIFO SHALL be one sub-module named ps2_tx_fifo (push, pop, dout, full, empty). The FSM and line drivers stay in ps2_device_tx.

Verification
REQ-032 Scenario: HALFBIT=4, IDLEWAIT=6, push 0x1C, host model samples on falling edges. Required: 11 falling edges carrying 0,0,0,1,1,1,0,0,0,0,1 (start, 0x1C LSB first, parity 0, stop); FIFO empty afterwards.
REQ-033 Scenario: push 0x00. Required: parity bit is 1.
REQ-034 Scenario: push 0xF0 then 0x1C back-to-back. Required: two frames in order, separated by at least IDLEWAIT cycles of idle bus.
REQ-035 Scenario: host pulls clock low during bit 5 of 0x5A. Required: aborted pulses once, both lines are released, and the full 0x5A frame is resent after the bus stays idle for IDLEWAIT cycles.
REQ-036 Scenario: DEPTH+1 pushes with the bus held inhibited. Required: fifo_full=1, the extra byte is dropped, and releasing the bus yields exactly DEPTH frames.
REQ-037 Scenario: rst_n pulled low mid-frame. Required: both lines read Z within the same cycle, ps2busy=0, fifo_empty=1.
